// File: rtl/main_fsm.sv
// -----------------------------------------------------------------------------
// main_fsm -- multicycle RISC-V control state machine
//
// Sequences each instruction through fetch / decode / execute / memory /
// writeback, driving the datapath mux selects, write strobes and the 2-bit
// ALUOp hint consumed by the ALU decoder. Every instruction fetch and every
// data access waits on mem_ready_i before completing.
//
// Optional feature macro: UPPER_IMM_EN
//   defined   : LUI (0110111) and AUIPC (0010111) are executed through the
//               LUI / AUIPC states and use the U-type immediate.
//   undefined : both opcodes are unsupported and lead to TRAP.
//
// Ports
//   clk_i         clock, all state changes on the rising edge
//   reset_i       synchronous, active-high reset
//   op_i          instr[6:0] from IR
//   funct3_i      instr[14:12]; bit 0 selects BNE vs BEQ
//   zero_i        ALU Zero flag
//   mem_ready_i   memory completes the current access this cycle
//   pc_write_o    PC load = pc_update | (branch & taken)
//   adr_src_o     memory address select: 0 PC, 1 ALUOut
//   mem_write_o   data-memory write strobe
//   ir_write_o    load IR and OldPC
//   reg_write_o   register-file write
//   result_src_o  00 ALUOut, 01 Data, 10 ALUResult
//   alu_src_a_o   00 PC, 01 OldPC, 10 rs1, 11 zero
//   alu_src_b_o   00 rs2, 01 ImmExt, 10 constant 4
//   imm_src_o     000 I, 001 S, 010 B, 011 J, 100 U (combinational from op_i)
//   alu_op_o      00 add, 01 subtract/compare, 10 funct-decoded
//   illegal_o     sticky flag: an unsupported opcode has been decoded
//   state_dbg_o   current state encoding
// -----------------------------------------------------------------------------
module main_fsm #(
   parameter int STATE_W = 4
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [6:0]         op_i,
   input  logic [2:0]         funct3_i,
   input  logic               zero_i,
   input  logic               mem_ready_i,
   output logic               pc_write_o,
   output logic               adr_src_o,
   output logic               mem_write_o,
   output logic               ir_write_o,
   output logic               reg_write_o,
   output logic [1:0]         result_src_o,
   output logic [1:0]         alu_src_a_o,
   output logic [1:0]         alu_src_b_o,
   output logic [2:0]         imm_src_o,
   output logic [1:0]         alu_op_o,
   output logic               illegal_o,
   output logic [STATE_W-1:0] state_dbg_o
);

   // Opcodes
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH    = STATE_W'(0),
      S_DECODE   = STATE_W'(1),
      S_MEMADR   = STATE_W'(2),
      S_MEMREAD  = STATE_W'(3),
      S_MEMWB    = STATE_W'(4),
      S_MEMWRITE = STATE_W'(5),
      S_EXECR    = STATE_W'(6),
      S_ALUWB    = STATE_W'(7),
      S_EXECI    = STATE_W'(8),
      S_JAL      = STATE_W'(9),
      S_BRANCH   = STATE_W'(10),
      S_LUI      = STATE_W'(11),
      S_AUIPC    = STATE_W'(12),
      S_TRAP     = STATE_W'(13)
   } state_t;

   state_t state_q, state_d;
   logic   illegal_q, illegal_d;

   // Internal strobes combined into pc_write_o
   logic pc_update;
   logic branch;
   logic taken;

   // funct3[2:1] are not needed for BEQ/BNE selection
   logic unused_funct3;
   assign unused_funct3 = ^funct3_i[2:1];

   // --------------------------------------------------------------------------
   // State and sticky illegal flag
   // --------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next state and Moore outputs
   // --------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      adr_src_o    = 1'b0;
      mem_write_o  = 1'b0;
      ir_write_o   = 1'b0;
      reg_write_o  = 1'b0;
      result_src_o = 2'b00;
      alu_src_a_o  = 2'b00;
      alu_src_b_o  = 2'b00;
      alu_op_o     = 2'b00;
      pc_update    = 1'b0;
      branch       = 1'b0;
      // BNE inverts the sense of Zero
      taken        = zero_i ^ funct3_i[0];

      case (state_q)
         S_FETCH: begin
            // ALU computes PC+4 while memory returns the instruction
            alu_src_b_o  = 2'b10;
            result_src_o = 2'b10;
            if (mem_ready_i) begin
               ir_write_o = 1'b1;
               pc_update  = 1'b1;
               state_d    = S_DECODE;
            end
         end

         S_DECODE: begin
            // OldPC + imm precomputes branch/JAL target into ALUOut
            alu_src_a_o = 2'b01;
            alu_src_b_o = 2'b01;
            case (op_i)
               OP_LOAD,
               OP_STORE:  state_d = S_MEMADR;
               OP_RTYPE:  state_d = S_EXECR;
               OP_ITYPE:  state_d = S_EXECI;
               OP_JAL:    state_d = S_JAL;
               OP_BRANCH: state_d = S_BRANCH;
`ifdef UPPER_IMM_EN
               OP_LUI:    state_d = S_LUI;
               OP_AUIPC:  state_d = S_AUIPC;
`endif
               default:   state_d = S_TRAP;
            endcase
         end

         S_MEMADR: begin
            alu_src_a_o = 2'b10;
            alu_src_b_o = 2'b01;
            state_d     = (op_i == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         end

         S_MEMREAD: begin
            adr_src_o = 1'b1;
            if (mem_ready_i) begin
               state_d = S_MEMWB;
            end
         end

         S_MEMWB: begin
            result_src_o = 2'b01;
            reg_write_o  = 1'b1;
            state_d      = S_FETCH;
         end

         S_MEMWRITE: begin
            adr_src_o = 1'b1;
            // Write strobe only on the cycle memory accepts it
            mem_write_o = mem_ready_i;
            if (mem_ready_i) begin
               state_d = S_FETCH;
            end
         end

         S_EXECR: begin
            alu_src_a_o = 2'b10;
            alu_op_o    = 2'b10;
            state_d     = S_ALUWB;
         end

         S_ALUWB: begin
            reg_write_o = 1'b1;
            state_d     = S_FETCH;
         end

         S_EXECI: begin
            alu_src_a_o = 2'b10;
            alu_src_b_o = 2'b01;
            alu_op_o    = 2'b10;
            state_d     = S_ALUWB;
         end

         S_JAL: begin
            // PC <- ALUOut (target), ALU forms OldPC+4 for rd
            alu_src_a_o = 2'b01;
            alu_src_b_o = 2'b10;
            pc_update   = 1'b1;
            state_d     = S_ALUWB;
         end

         S_BRANCH: begin
            alu_src_a_o = 2'b10;
            alu_op_o    = 2'b01;
            branch      = 1'b1;
            state_d     = S_FETCH;
         end

`ifdef UPPER_IMM_EN
         S_LUI: begin
            // zero + imm
            alu_src_a_o = 2'b11;
            alu_src_b_o = 2'b01;
            state_d     = S_ALUWB;
         end

         S_AUIPC: begin
            alu_src_a_o = 2'b01;
            alu_src_b_o = 2'b01;
            state_d     = S_ALUWB;
         end
`endif

         S_TRAP: begin
            state_d = S_TRAP;
         end

         default: begin
            state_d = S_FETCH;
         end
      endcase

      // Reset kills every strobe in the same cycle, even mid-access
      if (reset_i) begin
         state_d     = S_FETCH;
         ir_write_o  = 1'b0;
         mem_write_o = 1'b0;
         reg_write_o = 1'b0;
         pc_update   = 1'b0;
         branch      = 1'b0;
      end

      pc_write_o = pc_update | (branch & taken);
      // Flag rises on the same edge that enters TRAP
      illegal_d  = illegal_q | (state_d == S_TRAP);
   end

   // --------------------------------------------------------------------------
   // Immediate format select, decoded straight from the opcode
   // --------------------------------------------------------------------------
   always_comb begin
      imm_src_o = 3'b000;
      case (op_i)
         OP_STORE:  imm_src_o = 3'b001;
         OP_BRANCH: imm_src_o = 3'b010;
         OP_JAL:    imm_src_o = 3'b011;
`ifdef UPPER_IMM_EN
         OP_LUI,
         OP_AUIPC:  imm_src_o = 3'b100;
`endif
         default:   imm_src_o = 3'b000;
      endcase
   end

   assign illegal_o   = illegal_q;
   assign state_dbg_o = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// -----------------------------------------------------------------------------
// tb_main_fsm -- scoreboard bench for main_fsm
//
// The driver expands each instruction into its list of phases (with memory
// wait cycles), drives one cycle per phase and pushes the expected output
// vector for that cycle. The monitor pops one entry per falling edge and
// compares it against the DUT.
// -----------------------------------------------------------------------------
module tb_main_fsm;

   localparam int SW = 4;

   localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3;
   localparam int P_MEMWB = 4, P_MEMWRITE = 5, P_EXECR = 6, P_ALUWB = 7;
   localparam int P_EXECI = 8, P_JAL = 9, P_BRANCH = 10, P_LUI = 11;
   localparam int P_AUIPC = 12, P_TRAP = 13;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   logic          clk = 1'b0;
   logic          reset;
   logic [6:0]    op;
   logic [2:0]    funct3;
   logic          zero;
   logic          mem_ready;
   logic          pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
   logic [1:0]    result_src, alu_src_a, alu_src_b, alu_op;
   logic [2:0]    imm_src;
   logic [SW-1:0] state_dbg;

   typedef struct {
      logic [20:0] v;
      int          ph;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   ill_m   = 1'b0;
   bit   end_req = 1'b0;
   bit   end_ack = 1'b0;

   always #5 clk = ~clk;

   main_fsm #(.STATE_W(SW)) dut (
      .clk_i(clk), .reset_i(reset), .op_i(op), .funct3_i(funct3),
      .zero_i(zero), .mem_ready_i(mem_ready),
      .pc_write_o(pc_write), .adr_src_o(adr_src), .mem_write_o(mem_write),
      .ir_write_o(ir_write), .reg_write_o(reg_write),
      .result_src_o(result_src), .alu_src_a_o(alu_src_a),
      .alu_src_b_o(alu_src_b), .imm_src_o(imm_src), .alu_op_o(alu_op),
      .illegal_o(illegal), .state_dbg_o(state_dbg)
   );

   // Expected output vector for one cycle, straight from the state table
   function automatic logic [20:0] exp_vec(int ph, bit mr, bit rst,
                                           logic [6:0] o, logic [2:0] f,
                                           bit z, bit ill);
      logic       pcw, adr, mw, irw, rw;
      logic [1:0] rs, a, b, aop;
      logic [2:0] imm;
      pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0;
      rs = 2'b00; a = 2'b00; b = 2'b00; aop = 2'b00; imm = 3'b000;
      if (o == OP_STORE)  imm = 3'b001;
      if (o == OP_BRANCH) imm = 3'b010;
      if (o == OP_JAL)    imm = 3'b011;
`ifdef UPPER_IMM_EN
      if (o == OP_LUI || o == OP_AUIPC) imm = 3'b100;
`endif
      case (ph)
         P_FETCH:    begin b = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
         P_DECODE:   begin a = 2'b01; b = 2'b01; end
         P_MEMADR:   begin a = 2'b10; b = 2'b01; end
         P_MEMREAD:  adr = 1;
         P_MEMWB:    begin rs = 2'b01; rw = 1; end
         P_MEMWRITE: begin adr = 1; mw = mr; end
         P_EXECR:    begin a = 2'b10; aop = 2'b10; end
         P_ALUWB:    rw = 1;
         P_EXECI:    begin a = 2'b10; b = 2'b01; aop = 2'b10; end
         P_JAL:      begin a = 2'b01; b = 2'b10; pcw = 1; end
         P_BRANCH:   begin a = 2'b10; aop = 2'b01; pcw = z ^ f[0]; end
         P_LUI:      begin a = 2'b11; b = 2'b01; end
         P_AUIPC:    begin a = 2'b01; b = 2'b01; end
         default:    ;
      endcase
      if (rst) begin pcw = 0; irw = 0; mw = 0; rw = 0; end
      return {pcw, adr, mw, irw, rw, rs, a, b, imm, aop, ill, 4'(ph)};
   endfunction

   function automatic bit rb();
      return bit'($urandom_range(0, 1));
   endfunction

   // Drive one cycle and record what the DUT must show during it
   task automatic cyc(int ph, bit mr, bit rst);
      exp_t e;
      reset     = rst;
      mem_ready = mr;
      if (ph == P_TRAP) ill_m = 1'b1;
      e.v  = exp_vec(ph, mr, rst, op, funct3, zero, ill_m);
      e.ph = ph;
      q.push_back(e);
      if (rst) ill_m = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic mem_phase(int ph, int waits);
      repeat (waits) cyc(ph, 1'b0, 1'b0);
      cyc(ph, 1'b1, 1'b0);
   endtask

   task automatic run_instr(logic [6:0] o, logic [2:0] f, bit z, int fw, int mw);
      op = o; funct3 = f; zero = z;
      mem_phase(P_FETCH, fw);
      cyc(P_DECODE, rb(), 1'b0);
      case (o)
         OP_RTYPE:  begin cyc(P_EXECR, rb(), 0); cyc(P_ALUWB, rb(), 0); end
         OP_ITYPE:  begin cyc(P_EXECI, rb(), 0); cyc(P_ALUWB, rb(), 0); end
         OP_LOAD:   begin
            cyc(P_MEMADR, rb(), 0); mem_phase(P_MEMREAD, mw); cyc(P_MEMWB, rb(), 0);
         end
         OP_STORE:  begin cyc(P_MEMADR, rb(), 0); mem_phase(P_MEMWRITE, mw); end
         OP_BRANCH: cyc(P_BRANCH, rb(), 0);
         OP_JAL:    begin cyc(P_JAL, rb(), 0); cyc(P_ALUWB, rb(), 0); end
`ifdef UPPER_IMM_EN
         OP_LUI:    begin cyc(P_LUI, rb(), 0); cyc(P_ALUWB, rb(), 0); end
         OP_AUIPC:  begin cyc(P_AUIPC, rb(), 0); cyc(P_ALUWB, rb(), 0); end
`endif
         default: begin
            // Trap holds regardless of inputs until a two-cycle reset
            repeat (3) cyc(P_TRAP, rb(), 1'b0);
            cyc(P_TRAP, rb(), 1'b1);
            cyc(P_FETCH, rb(), 1'b1);
         end
      endcase
   endtask

   // Monitor
   always @(negedge clk) begin
      exp_t        e;
      logic [20:0] act;
      act = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
             alu_src_a, alu_src_b, imm_src, alu_op, illegal, state_dbg};
      if (q.size() > 0) begin
         e = q.pop_front();
         n_tests++;
         if (act !== e.v) begin
            n_fail++;
            $display("FAIL cycle phase=%0d t=%0t actual=%h expected=%h",
                     e.ph, $time, act, e.v);
         end
      end else if (end_req && !end_ack) begin
         n_tests++;
         end_ack = 1'b1;
      end
   end

   initial begin
      logic [6:0] ops [9];
      logic [6:0] o;
      ops = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BRANCH,
              OP_LUI, OP_AUIPC, 7'b1111111};
      reset = 1'b1; op = OP_RTYPE; funct3 = 3'b000; zero = 1'b0; mem_ready = 1'b0;
      @(posedge clk); #1;
      cyc(P_FETCH, 1'b0, 1'b1);
      cyc(P_FETCH, 1'b1, 1'b1);

      // R-type, no waits
      run_instr(OP_RTYPE, 3'b000, 1'b0, 0, 0);
      // Load with three MEMREAD wait cycles
      run_instr(OP_LOAD, 3'b010, 1'b0, 0, 3);
      // Store with waits
      run_instr(OP_STORE, 3'b010, 1'b1, 1, 2);
      // Branch sense combinations
      run_instr(OP_BRANCH, 3'b000, 1'b1, 0, 0);
      run_instr(OP_BRANCH, 3'b001, 1'b1, 0, 0);
      run_instr(OP_BRANCH, 3'b001, 1'b0, 0, 0);
      run_instr(OP_BRANCH, 3'b000, 1'b0, 0, 0);
      // LUI: executes or traps depending on build
      run_instr(OP_LUI, 3'b000, 1'b0, 0, 0);
      run_instr(OP_JAL, 3'b000, 1'b0, 2, 0);

      // Reset arriving in MEMWRITE with memory ready: no write issued
      op = OP_STORE; funct3 = 3'b010; zero = 1'b0;
      cyc(P_FETCH, 1'b1, 1'b0);
      cyc(P_DECODE, 1'b1, 1'b0);
      cyc(P_MEMADR, 1'b1, 1'b0);
      cyc(P_MEMWRITE, 1'b1, 1'b1);
      run_instr(OP_ITYPE, 3'b000, 1'b1, 0, 0);

      // Random instruction stream
      for (int i = 0; i < 80; i++) begin
         o = ops[$urandom_range(0, 8)];
         if ($urandom_range(0, 9) == 0) o = 7'($urandom_range(0, 127));
         run_instr(o, 3'($urandom_range(0, 7)), rb(),
                   $urandom_range(0, 3), $urandom_range(0, 3));
      end

      // Drain: the monitor must consume every expectation
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      end_req = 1'b1;
      for (int i = 0; i < 10 && !end_ack; i++) @(posedge clk);
      #1;
      if (q.size() != 0 || !end_ack) begin
         $display("FAIL drain pending=%0d required=0", q.size());
         $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      end else begin
         $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      end
      $finish;
   end

endmodule
